datapath_pipe: RTL
==================

# datapath_pipe

Parametrised two-stage register-file/ALU datapath for the 64-bit processor datapath; successor of the original unpipelined register-file + ALU + RAM top level. Accepts one operation per cycle (source regs, destination reg, function select), reads operands in stage 1, executes and writes back in stage 2, with full forwarding so back-to-back dependent operations never stall. A side write port loads external data (e.g. RAM read data) into the register file through a valid/ack handshake.

## Interface
- WIDTH, 64, datapath width in bits (≥8)
- REGS, 32, register count (power of two); register REGS-1 reads as zero, writes to it are dropped
- AW, $clog2(REGS), register address width (derived, not overridden)

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- op_valid  in  1  issue an operation this cycle
- op_sa  in  AW  source A register
- op_sb  in  AW  source B register
- op_imm_sel  in  1  1: operand B = op_imm instead of register op_sb
- op_imm  in  WIDTH  immediate operand
- op_fs  in  5  function select
- op_cin  in  1  carry-in for ADD
- op_da  in  AW  destination register
- op_wb  in  1  1: write result to op_da
- ext_valid  in  1  external write request; held until acked
- ext_addr  in  AW  external write register
- ext_data  in  WIDTH  external write data
- ext_ack  out  1  external write committed at this edge
- res_valid  out  1  result/status valid (one cycle per op)
- res_data  out  WIDTH  registered ALU result
- res_da  out  AW  destination of that result
- status  out  4  {V,C,N,Z} of that result

## Operation
- FS codes: 0 PASS_A, 1 PASS_B, 2 AND, 3 OR, 4 XOR, 5 NOT_A, 6 ADD (A+B+cin), 7 SUB (A+~B+1), 8 SHL (A<<B[log2(WIDTH)-1:0]), 9 SHR logical; 10–31 result 0.
- Flags: N = result[WIDTH-1]; Z = (result==0); C = carry out of WIDTH-bit sum for ADD/SUB (SUB: C=1 means no borrow), else 0; V = signed overflow for ADD/SUB, else 0.
- Stage 1 (issue cycle): read A/B from register file with bypass; capture operands, fs, cin, da, wb, valid into S1 registers.
- Stage 2: ALU combinational on S1; at edge capture res_data/res_da/status, res_valid = S1 valid; if S1 valid and wb and da≠REGS-1, write register file.
- Bypass priority for a source read in the issue cycle: register REGS-1 → 0; else stage-2 writeback to same register → ALU result; else acked ext write to same register → ext_data; else register file.
- ext write: ext_ack=1 (combinational, same cycle) when ext_valid and no stage-2 writeback this cycle; data committed at that edge. Otherwise request waits; requester holds ext_addr/ext_data stable. ext write to REGS-1 is acked and dropped.
- Pipeline never stalls; op_valid is always accepted.

## Timing
- Op issued in cycle t: operands captured edge t; result, status, register write at edge t+1; res_valid high during cycle t+2 only.
- Dependent op in cycle t+1 sees result via forward; in t+2 or later via register file.
- ext_ack same cycle as request when no writeback conflict; otherwise first cycle without stage-2 writeback.
- Reset (async, reset=0): all registers 0, S1 valid 0, res_valid 0, res_data 0, res_da 0, status 0; ext_ack 0 while reset low. In-flight ops discarded, no writeback. First op after release behaves normally.

## Structure
- Package datapath_pkg: FS code constants, status bit indices (V=3,C=2,N=1,Z=0).
- Sub-module alu (WIDTH param): combinational result + 4-bit status from A, B, fs, cin.
- Register file inline (flop array, two read, one write port + bypass muxes).

## Test plan
- Reset release; ext write 7364 to r3, then op PASS_A sa=3 → res_valid at t+2, res_data 7364, status 0000.
- r1=0x7FFF_FFFF_FFFF_FFFF, r2=1, ADD → 0x8000_0000_0000_0000, status V=1,C=0,N=1,Z=0; SUB r2−r2 → 0, status C=1,Z=1.
- Back-to-back: ADD r4=r1+r2 at t, ADD r5=r4+r4 at t+1 → r5 correct via forward, no stall.
- ext_valid to r6 in same cycle as stage-2 writeback → ext_ack 0 that cycle, 1 next; r6 holds ext_data; simultaneous op reading r6 in ack cycle gets ext_data.
- Writes to r31 (op and ext) dropped; reads of r31 give 0; FS=20 → res_data 0, Z=1.
- Assert reset with ops in both stages → no register changes, outputs 0; resume cleanly.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared constants for the two-stage register-file/ALU datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package datapath_pkg;

  localparam int FS_W = 5;

  // Function select codes. Any code above FS_SHR produces a zero result.
  localparam logic [FS_W-1:0] FS_PASS_A = 5'd0;
  localparam logic [FS_W-1:0] FS_PASS_B = 5'd1;
  localparam logic [FS_W-1:0] FS_AND    = 5'd2;
  localparam logic [FS_W-1:0] FS_OR     = 5'd3;
  localparam logic [FS_W-1:0] FS_XOR    = 5'd4;
  localparam logic [FS_W-1:0] FS_NOT_A  = 5'd5;
  localparam logic [FS_W-1:0] FS_ADD    = 5'd6;
  localparam logic [FS_W-1:0] FS_SUB    = 5'd7;
  localparam logic [FS_W-1:0] FS_SHL    = 5'd8;
  localparam logic [FS_W-1:0] FS_SHR    = 5'd9;

  // Bit positions inside the 4-bit {V,C,N,Z} status word.
  localparam int ST_V = 3;
  localparam int ST_C = 2;
  localparam int ST_N = 1;
  localparam int ST_Z = 0;

endpackage

// File: rtl/datapath_pipe_if.sv
// Bundles the issue port, external write port and result port of datapath_pipe.
// Latency: n/a (wiring only).
// Backpressure: none on ops; ext writes wait on ext_ack.
// Ports: master = op/ext driver, slave = datapath_pipe.
interface datapath_pipe_if
  import datapath_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int AW    = 5
);
  logic             op_valid;
  logic [AW-1:0]    op_sa;
  logic [AW-1:0]    op_sb;
  logic             op_imm_sel;
  logic [WIDTH-1:0] op_imm;
  logic [FS_W-1:0]  op_fs;
  logic             op_cin;
  logic [AW-1:0]    op_da;
  logic             op_wb;

  logic             ext_valid;
  logic [AW-1:0]    ext_addr;
  logic [WIDTH-1:0] ext_data;
  logic             ext_ack;

  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic [AW-1:0]    res_da;
  logic [3:0]       status;

  modport master (
    output op_valid, op_sa, op_sb, op_imm_sel, op_imm, op_fs, op_cin, op_da, op_wb,
    output ext_valid, ext_addr, ext_data,
    input  ext_ack,
    input  res_valid, res_data, res_da, status
  );

  modport slave (
    input  op_valid, op_sa, op_sb, op_imm_sel, op_imm, op_fs, op_cin, op_da, op_wb,
    input  ext_valid, ext_addr, ext_data,
    output ext_ack,
    output res_valid, res_data, res_da, status
  );

endinterface

// File: rtl/datapath_pipe_alu.sv
// Combinational ALU: result and {V,C,N,Z} status from a, b, fs, cin.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: a/b operands, fs function select, cin ADD carry-in -> result, status.
module alu
  import datapath_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [FS_W-1:0]  fs,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       status
);

  localparam int SW = $clog2(WIDTH);

  logic [WIDTH-1:0] b_add;
  logic             carry_in;
  logic [WIDTH:0]   sum;
  logic             is_arith;

  always_comb begin
    // ADD and SUB share one adder: SUB is A + ~B + 1, so the carry out
    // reads as "no borrow".
    b_add    = (fs == FS_SUB) ? ~b : b;
    carry_in = (fs == FS_SUB) ? 1'b1 : cin;
    sum      = {1'b0, a} + {1'b0, b_add} + {{WIDTH{1'b0}}, carry_in};
    is_arith = (fs == FS_ADD) || (fs == FS_SUB);

    result = '0;
    case (fs)
      FS_PASS_A: result = a;
      FS_PASS_B: result = b;
      FS_AND:    result = a & b;
      FS_OR:     result = a | b;
      FS_XOR:    result = a ^ b;
      FS_NOT_A:  result = ~a;
      FS_ADD,
      FS_SUB:    result = sum[WIDTH-1:0];
      FS_SHL:    result = a << b[SW-1:0];
      FS_SHR:    result = a >> b[SW-1:0];
      default:   result = '0;
    endcase

    status       = '0;
    status[ST_N] = result[WIDTH-1];
    status[ST_Z] = (result == '0);
    if (is_arith) begin
      status[ST_C] = sum[WIDTH];
      // Overflow: both adder inputs share a sign that the sum does not.
      status[ST_V] = (a[WIDTH-1] == b_add[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end
  end

endmodule

// File: rtl/datapath_pipe.sv
// Two-stage register-file/ALU datapath with full forwarding and a side write port.
// Latency: op issued in cycle t -> res_valid in cycle t+2; register written at edge t+1.
// Backpressure: ops never stall; ext writes wait while a stage-2 writeback owns the write port.
// Ports: clock, reset (async active-low), io (slave modport: op issue, ext write, result).
module datapath_pipe
  import datapath_pkg::*;
#(
  parameter  int WIDTH = 64,
  parameter  int REGS  = 32,
  localparam int AW    = $clog2(REGS)
) (
  input  logic           clock,
  input  logic           reset,
  datapath_pipe_if.slave io
);

  // Highest register is hardwired to zero.
  localparam logic [AW-1:0] ZREG = AW'(REGS - 1);

  logic [WIDTH-1:0] rf [REGS];

  // Stage-1 registers (operands already bypassed).
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [FS_W-1:0]  s1_fs;
  logic             s1_cin;
  logic [AW-1:0]    s1_da;
  logic             s1_wb;

  logic [WIDTH-1:0] alu_res;
  logic [3:0]       alu_st;

  logic             wb_en;
  logic             ext_ack_int;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;

  logic             res_valid_q;
  logic [WIDTH-1:0] res_data_q;
  logic [AW-1:0]    res_da_q;
  logic [3:0]       status_q;

  alu #(.WIDTH(WIDTH)) u_alu (
    .a      (s1_a),
    .b      (s1_b),
    .fs     (s1_fs),
    .cin    (s1_cin),
    .result (alu_res),
    .status (alu_st)
  );

  // The single write port belongs to stage 2 first; ext writes take idle cycles.
  assign wb_en       = s1_valid && s1_wb && (s1_da != ZREG);
  assign ext_ack_int = reset && io.ext_valid && !wb_en;

  // Source read with bypass: zero reg, then stage-2 result, then the ext
  // write landing at this same edge, then the array.
  always_comb begin
    rd_a = rf[io.op_sa];
    if (io.op_sa == ZREG)                            rd_a = '0;
    else if (wb_en && (s1_da == io.op_sa))           rd_a = alu_res;
    else if (ext_ack_int && (io.ext_addr == io.op_sa)) rd_a = io.ext_data;

    rd_b = rf[io.op_sb];
    if (io.op_sb == ZREG)                            rd_b = '0;
    else if (wb_en && (s1_da == io.op_sb))           rd_b = alu_res;
    else if (ext_ack_int && (io.ext_addr == io.op_sb)) rd_b = io.ext_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REGS; i++) rf[i] <= '0;
    end else if (wb_en) begin
      rf[s1_da] <= alu_res;
    end else if (ext_ack_int && (io.ext_addr != ZREG)) begin
      rf[io.ext_addr] <= io.ext_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_fs    <= '0;
      s1_cin   <= 1'b0;
      s1_da    <= '0;
      s1_wb    <= 1'b0;
    end else begin
      s1_valid <= io.op_valid;
      s1_a     <= rd_a;
      s1_b     <= io.op_imm_sel ? io.op_imm : rd_b;
      s1_fs    <= io.op_fs;
      s1_cin   <= io.op_cin;
      s1_da    <= io.op_da;
      s1_wb    <= io.op_wb;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_da_q    <= '0;
      status_q    <= '0;
    end else begin
      res_valid_q <= s1_valid;
      res_data_q  <= alu_res;
      res_da_q    <= s1_da;
      status_q    <= alu_st;
    end
  end

  assign io.ext_ack   = ext_ack_int;
  assign io.res_valid = res_valid_q;
  assign io.res_data  = res_data_q;
  assign io.res_da    = res_da_q;
  assign io.status    = status_q;

endmodule
